fetch_unit: RTL and testbench

- Instruction-fetch and PC-update stage directly upstream of the decode/control stage.
- Holds the program counter and fetches one 32-bit instruction from instruction memory using a req/rvalid handshake.
- Presents the instruction to decode for one execute cycle.
- Consumes decode's pc_write/pc_sel plus the immediate and ALU zero flag to compute the next PC; traps on misaligned targets and fetch timeouts.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-update stage: fetches one word per instruction over a
// req/rvalid handshake, holds it for decode during EXEC, then commits the next PC.
module fetch_unit #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = {XLEN{1'b0}},
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_zero,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    output logic [31:0]     instr_o,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misaligned_err,
    output logic            fetch_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    localparam logic [1:0] PC_4      = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);

    localparam int                CNT_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [XLEN-1:0]  pc_s;
    logic [31:0]      instr_s;
    logic             fetch_err_s;
    logic             misaligned_err_s;

    logic [XLEN-1:0]  pc_plus4_s;
    logic [XLEN-1:0]  pc_target_s;
    logic [XLEN-1:0]  pc_next_s;
    logic             pc_hold_s;
    logic             pc_misaligned_s;

    assign pc_plus4_s  = pc_o + PC_STEP;
    assign pc_target_s = pc_o + imm;
    assign pc_plus4_o  = pc_plus4_s;
    assign imem_addr   = pc_o;

    // Next-PC selection from decode controls; a held PC is always aligned.
    always_comb begin
        pc_next_s       = pc_o;
        pc_hold_s       = 1'b0;
        pc_misaligned_s = 1'b0;
        case (pc_sel)
            PC_4:      pc_next_s = pc_plus4_s;
            PC_BRANCH: pc_next_s = alu_zero ? pc_target_s : pc_plus4_s;
            PC_JAL:    pc_next_s = pc_target_s;
            default:   pc_next_s = pc_o;
        endcase
        if (!pc_write || (pc_sel == 2'b11)) begin
            pc_hold_s = 1'b1;
        end else begin
            pc_hold_s = 1'b0;
        end
        if (!pc_hold_s && (pc_next_s[1:0] != 2'b00)) begin
            pc_misaligned_s = 1'b1;
        end else begin
            pc_misaligned_s = 1'b0;
        end
    end

    // FSM next-state, timeout counter and architectural state updates.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        pc_s             = pc_o;
        instr_s          = instr_o;
        fetch_err_s      = fetch_err;
        misaligned_err_s = misaligned_err;
        case (state_r)
            S_IDLE: begin
                state_s = S_FETCH;
                cnt_s   = CNT_ZERO;
            end
            S_FETCH: begin
                // A response on the final allowed cycle still completes the fetch.
                if (imem_rvalid) begin
                    instr_s = imem_rdata;
                    cnt_s   = CNT_ZERO;
                    state_s = S_EXEC;
                end else if (cnt_r >= CNT_LAST) begin
                    fetch_err_s = 1'b1;
                    state_s     = S_TRAP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_EXEC: begin
                if (stall) begin
                    state_s = S_EXEC;
                end else if (pc_hold_s) begin
                    state_s = S_FETCH;
                end else if (pc_misaligned_s) begin
                    misaligned_err_s = 1'b1;
                    state_s          = S_TRAP;
                end else begin
                    pc_s    = pc_next_s;
                    state_s = S_FETCH;
                end
            end
            S_TRAP: begin
                state_s = S_TRAP;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State registers; handshake flags are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            cnt_r          <= CNT_ZERO;
            pc_o           <= RESET_PC;
            instr_o        <= NOP_INSTR;
            instr_valid    <= 1'b0;
            imem_req       <= 1'b0;
            fetch_err      <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            pc_o           <= pc_s;
            instr_o        <= instr_s;
            instr_valid    <= (state_s == S_EXEC);
            imem_req       <= (state_s == S_FETCH);
            fetch_err      <= fetch_err_s;
            misaligned_err <= misaligned_err_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/JAL, stall/hold,
// misalignment and timeout traps, mid-fetch reset and PC wrap.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic [31:0] imm;
    logic        alu_zero;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        misaligned_err;
    logic        fetch_err;

    int total;
    int bad;

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .FETCH_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_write(pc_write),
        .pc_sel(pc_sel),
        .imm(imm),
        .alu_zero(alu_zero),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid),
        .instr_o(instr_o),
        .instr_valid(instr_valid),
        .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o),
        .misaligned_err(misaligned_err),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects the DUT in FETCH at addr; memory answers one cycle after the request.
    task automatic fetch_instr(input logic [31:0] addr, input logic [31:0] word);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        chk("fetch_ivalid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("fetch_req_hold", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr_hold", imem_addr, addr);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk("exec_ivalid", {31'd0, instr_valid}, 32'd1);
        chk("exec_instr", instr_o, word);
        chk("exec_req", {31'd0, imem_req}, 32'd0);
        chk("exec_pc", pc_o, addr);
        chk("exec_pc4", pc_plus4_o, addr + 32'd4);
    endtask

    task automatic exec_step(input logic pw, input logic [1:0] sel,
                             input logic [31:0] im, input logic az);
        pc_write = pw;
        pc_sel   = sel;
        imm      = im;
        alu_zero = az;
        stall    = 1'b0;
        tick();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 2'b00;
        imm         = 32'h0000_0000;
        alu_zero    = 1'b0;
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        tick();
        tick();
        chk("rst_pc", pc_o, 32'h0000_0000);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_pc4", pc_plus4_o, 32'h0000_0004);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_merr", {31'd0, misaligned_err}, 32'd0);
        chk("rst_ferr", {31'd0, fetch_err}, 32'd0);

        // Sequential fetch 0x0, 0x4, 0x8 ... up to 0x10.
        rst_n = 1'b1;
        tick();
        fetch_instr(32'h0000_0000, 32'h0010_0093);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);
        chk("ivalid_pulse", {31'd0, instr_valid}, 32'd0);
        fetch_instr(32'h0000_0004, 32'h0020_0113);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);
        fetch_instr(32'h0000_0008, 32'h0030_0193);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);
        fetch_instr(32'h0000_000C, 32'h0040_0213);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);

        // Branch taken from 0x10 by -8, then not taken.
        fetch_instr(32'h0000_0010, 32'hFE00_0CE3);
        exec_step(1'b1, 2'b01, 32'hFFFF_FFF8, 1'b1);
        chk("br_taken_pc", pc_o, 32'h0000_0008);
        fetch_instr(32'h0000_0008, 32'h0030_0193);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);
        fetch_instr(32'h0000_000C, 32'h0040_0213);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);
        fetch_instr(32'h0000_0010, 32'hFE00_0CE3);
        exec_step(1'b1, 2'b01, 32'hFFFF_FFF8, 1'b0);
        chk("br_not_taken_pc", pc_o, 32'h0000_0014);

        // JAL to 0x20, then stall for three cycles.
        fetch_instr(32'h0000_0014, 32'h00C0_006F);
        exec_step(1'b1, 2'b10, 32'h0000_000C, 1'b0);
        chk("jal_pc", pc_o, 32'h0000_0020);
        fetch_instr(32'h0000_0020, 32'h0400_006F);
        pc_write = 1'b1;
        pc_sel   = 2'b10;
        imm      = 32'h0000_0040;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ivalid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc_o, 32'h0000_0020);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_instr", instr_o, 32'h0400_006F);
        end

        // pc_write = 0 and pc_sel = 11 both refetch the same address.
        exec_step(1'b0, 2'b00, 32'h0, 1'b0);
        chk("nowrite_pc", pc_o, 32'h0000_0020);
        fetch_instr(32'h0000_0020, 32'h0400_006F);
        exec_step(1'b1, 2'b11, 32'h0000_0040, 1'b0);
        chk("hold_pc", pc_o, 32'h0000_0020);
        fetch_instr(32'h0000_0020, 32'h0400_006F);
        exec_step(1'b1, 2'b10, 32'h0000_0040, 1'b0);
        chk("jal40_pc", pc_o, 32'h0000_0060);

        // JAL by 6 is misaligned: trap with PC frozen.
        fetch_instr(32'h0000_0060, 32'h0060_006F);
        exec_step(1'b1, 2'b10, 32'h0000_0006, 1'b0);
        chk("mis_err", {31'd0, misaligned_err}, 32'd1);
        chk("mis_pc", pc_o, 32'h0000_0060);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("mis_ferr", {31'd0, fetch_err}, 32'd0);
        imem_rvalid = 1'b1;
        tick();
        tick();
        imem_rvalid = 1'b0;
        chk("trap_req", {31'd0, imem_req}, 32'd0);
        chk("trap_pc", pc_o, 32'h0000_0060);
        chk("trap_merr_sticky", {31'd0, misaligned_err}, 32'd1);
        chk("trap_instr", instr_o, 32'h0060_006F);

        // Timeout with no response: four FETCH cycles then trap.
        rst_n = 1'b0;
        tick();
        chk("rst2_merr", {31'd0, misaligned_err}, 32'd0);
        chk("rst2_pc", pc_o, 32'h0000_0000);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_ferr", {31'd0, fetch_err}, 32'd0);
            chk("to_wait_req", {31'd0, imem_req}, 32'd1);
        end
        tick();
        chk("to_ferr", {31'd0, fetch_err}, 32'd1);
        chk("to_req", {31'd0, imem_req}, 32'd0);
        chk("to_ivalid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("to_ferr_sticky", {31'd0, fetch_err}, 32'd1);

        // Response on exactly the fourth FETCH cycle wins over the timeout.
        rst_n = 1'b0;
        tick();
        chk("rst3_ferr", {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFC0_006F;
        tick();
        imem_rvalid = 1'b0;
        chk("late_ferr", {31'd0, fetch_err}, 32'd0);
        chk("late_ivalid", {31'd0, instr_valid}, 32'd1);
        chk("late_instr", instr_o, 32'hFFC0_006F);

        // JAL to 0xFFFF_FFFC, then PC_4 wraps to zero.
        exec_step(1'b1, 2'b10, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_o, 32'h0000_0000);
        fetch_instr(32'hFFFF_FFFC, 32'h0010_0093);
        exec_step(1'b1, 2'b00, 32'h0, 1'b0);
        chk("wrap_next_pc", pc_o, 32'h0000_0000);

        // Reset during FETCH; a late rvalid while IDLE is ignored.
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_instr", instr_o, 32'h0000_0013);
        chk("mid_req_rst", {31'd0, imem_req}, 32'd0);
        chk("mid_ivalid", {31'd0, instr_valid}, 32'd0);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        chk("idle_ignore_instr", instr_o, 32'h0000_0013);
        chk("idle_ignore_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("idle_then_fetch", {31'd0, imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
